// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the hazard/trap controller.
// Per-stage control bundle, bypass selects and trap FSM states.
package pipeline_hazard_ctrl_pkg;

    typedef struct packed {
        logic stall;
        logic flush;
    } control;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2,
        FWD_WB  = 2'd3
    } fwd_sel_e;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } trap_state_e;

    localparam control CTRL_NONE  = '{stall: 1'b0, flush: 1'b0};
    localparam control CTRL_STALL = '{stall: 1'b1, flush: 1'b0};
    localparam control CTRL_FLUSH = '{stall: 1'b0, flush: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_scoreboard.sv
// Busy-bit scoreboard for results owed by the multi-cycle EX unit.
// Two source read ports plus a destination check.
module hazard_scoreboard
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              setEn,
    input  logic [REG_AW-1:0] setAddr,
    input  logic              clrEn,
    input  logic [REG_AW-1:0] clrAddr,
    input  logic [REG_AW-1:0] rs1Addr,
    input  logic [REG_AW-1:0] rs2Addr,
    input  logic [REG_AW-1:0] rdAddr,
    output logic              rs1Busy,
    output logic              rs2Busy,
    output logic              rdBusy
);

    localparam int N = 2 ** REG_AW;

    logic [N-1:0] busy;
    logic [N-1:0] busyNext;

    always_comb begin
        busyNext = busy;
        if (clrEn) busyNext[clrAddr] = 1'b0;
        if (setEn) busyNext[setAddr] = 1'b1;
        if (flush) busyNext = '0;
    end

    always_ff @(posedge clock) begin
        if (reset) busy <= '0;
        else       busy <= busyNext;
    end

    assign rs1Busy = busy[rs1Addr];
    assign rs2Busy = busy[rs2Addr];
    // A retiring write to the same rd is no WAW hazard: the reissue lands later.
    assign rdBusy  = busy[rdAddr] & ~(clrEn & (clrAddr == rdAddr));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard/trap controller: RAW bypass/bubbles, multi-cycle
// scoreboard, trap drain FSM and stall watchdog for the 5-stage core.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int FORWARDING  = 1,
    parameter int TRAP_DRAIN  = 2,
    parameter int STALL_LIMIT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              decodeValid,
    input  logic [REG_AW-1:0] decodeRs1,
    input  logic [REG_AW-1:0] decodeRs2,
    input  logic              decodeUsesRs1,
    input  logic              decodeUsesRs2,
    input  logic [REG_AW-1:0] decodeRd,
    input  logic              decodeMulti,
    input  logic              decodeExecuteValid,
    input  logic              decodeExecuteIllegal,
    input  logic [REG_AW-1:0] executeRd,
    input  logic              executeWrites,
    input  logic              executeIsLoad,
    input  logic [REG_AW-1:0] memoryRd,
    input  logic              memoryWrites,
    input  logic              memoryWritebackValid,
    input  logic              memoryWritebackIllegal,
    input  logic [REG_AW-1:0] writebackRd,
    input  logic              writebackWrites,
    input  logic              multiDone,
    input  logic [REG_AW-1:0] multiRd,
    input  logic              branchValid,
    input  logic              stallControl,
    output control            fetchDecodeControl,
    output control            decodeExecuteControl,
    output control            executeMemoryControl,
    output control            memoryWritebackControl,
    output logic [1:0]        forwardSel1,
    output logic [1:0]        forwardSel2,
    output logic              controlReset,
    output logic              stallTimeout
);

    localparam int CW = $clog2(STALL_LIMIT + 1);
    localparam int DW = (TRAP_DRAIN > 1) ? $clog2(TRAP_DRAIN) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(TRAP_DRAIN - 1);
    localparam logic [CW-1:0] LIMIT = CW'(STALL_LIMIT);
    localparam bit FWD_ON = (FORWARDING != 0);

    function automatic logic hit(
        input logic [REG_AW-1:0] rs,
        input logic              used,
        input logic [REG_AW-1:0] rd,
        input logic              wr
    );
        return used && (rs != '0) && wr && (rs == rd);
    endfunction

    trap_state_e       state;
    logic [DW-1:0]     drainCnt;
    logic [CW-1:0]     stallCount;
    logic [CW-1:0]     stallNext;
    logic              timeoutQ;

    logic deTrap, mwTrap, trapAccept;
    logic ex1, ex2, mem1, mem2, wb1, wb2;
    logic raw1, raw2, sbHazard, hazard;
    logic rs1Busy, rs2Busy, rdBusy;
    logic sbSet;
    fwd_sel_e sel1, sel2;

    assign deTrap = decodeExecuteValid & decodeExecuteIllegal;
    assign mwTrap = memoryWritebackValid & memoryWritebackIllegal;
    assign trapAccept = (state == IDLE) & (deTrap | mwTrap);

    assign ex1  = hit(decodeRs1, decodeUsesRs1, executeRd, executeWrites);
    assign ex2  = hit(decodeRs2, decodeUsesRs2, executeRd, executeWrites);
    assign mem1 = hit(decodeRs1, decodeUsesRs1, memoryRd, memoryWrites);
    assign mem2 = hit(decodeRs2, decodeUsesRs2, memoryRd, memoryWrites);
    assign wb1  = hit(decodeRs1, decodeUsesRs1, writebackRd, writebackWrites);
    assign wb2  = hit(decodeRs2, decodeUsesRs2, writebackRd, writebackWrites);

    assign raw1 = FWD_ON ? (ex1 & executeIsLoad) : (ex1 | mem1 | wb1);
    assign raw2 = FWD_ON ? (ex2 & executeIsLoad) : (ex2 | mem2 | wb2);

    assign sbHazard = (decodeUsesRs1 & (decodeRs1 != '0) & rs1Busy)
                    | (decodeUsesRs2 & (decodeRs2 != '0) & rs2Busy)
                    | ((decodeRd != '0) & rdBusy);
    assign hazard = decodeValid & (raw1 | raw2 | sbHazard);

    always_comb begin
        sel1 = FWD_RF;
        if (ex1)       sel1 = executeIsLoad ? FWD_RF : FWD_EX;
        else if (mem1) sel1 = FWD_MEM;
        else if (wb1)  sel1 = FWD_WB;
        sel2 = FWD_RF;
        if (ex2)       sel2 = executeIsLoad ? FWD_RF : FWD_EX;
        else if (mem2) sel2 = FWD_MEM;
        else if (wb2)  sel2 = FWD_WB;
    end

    assign forwardSel1 = (FWD_ON && !reset) ? sel1 : FWD_RF;
    assign forwardSel2 = (FWD_ON && !reset) ? sel2 : FWD_RF;

    always_comb begin
        fetchDecodeControl     = CTRL_NONE;
        decodeExecuteControl   = CTRL_NONE;
        executeMemoryControl   = CTRL_NONE;
        memoryWritebackControl = CTRL_NONE;
        controlReset           = 1'b0;
        if (reset) begin
            controlReset = 1'b0;
        end else if (state == DRAIN) begin
            fetchDecodeControl     = CTRL_FLUSH;
            decodeExecuteControl   = CTRL_FLUSH;
            executeMemoryControl   = CTRL_FLUSH;
            memoryWritebackControl = CTRL_FLUSH;
        end else if (deTrap | mwTrap) begin
            fetchDecodeControl     = CTRL_FLUSH;
            decodeExecuteControl   = CTRL_FLUSH;
            executeMemoryControl   = CTRL_FLUSH;
            if (mwTrap) memoryWritebackControl = CTRL_FLUSH;
            controlReset = 1'b1;
        end else if (branchValid) begin
            fetchDecodeControl   = CTRL_FLUSH;
            decodeExecuteControl = CTRL_FLUSH;
        end else if (stallControl) begin
            fetchDecodeControl     = CTRL_STALL;
            decodeExecuteControl   = CTRL_STALL;
            executeMemoryControl   = CTRL_STALL;
            memoryWritebackControl = CTRL_STALL;
        end else if (hazard) begin
            fetchDecodeControl   = CTRL_STALL;
            decodeExecuteControl = CTRL_FLUSH;
        end
    end

    assign sbSet = decodeValid & decodeMulti & (decodeRd != '0)
                 & ~fetchDecodeControl.stall
                 & ~decodeExecuteControl.flush;

    hazard_scoreboard #(.REG_AW(REG_AW)) scoreboard (
        .clock   (clock),
        .reset   (reset),
        .flush   (trapAccept),
        .setEn   (sbSet),
        .setAddr (decodeRd),
        .clrEn   (multiDone),
        .clrAddr (multiRd),
        .rs1Addr (decodeRs1),
        .rs2Addr (decodeRs2),
        .rdAddr  (decodeRd),
        .rs1Busy (rs1Busy),
        .rs2Busy (rs2Busy),
        .rdBusy  (rdBusy)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            drainCnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trapAccept) begin
                        state    <= DRAIN;
                        drainCnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) state <= IDLE;
                    else drainCnt <= drainCnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        stallNext = '0;
        if (fetchDecodeControl.stall)
            stallNext = (stallCount == LIMIT) ? LIMIT : stallCount + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stallCount <= '0;
            timeoutQ   <= 1'b0;
        end else begin
            stallCount <= stallNext;
            if (stallNext == LIMIT) timeoutQ <= 1'b1;
        end
    end

    assign stallTimeout = timeoutQ & ~reset;

endmodule
